// File: rtl/decimating_strobe_source.sv
// Boxcar decimator: averages 2^dec samples per window and emits a strobe (ce_o)
// at every window boundary plus a valid pulse when the whole window was enabled.
module decimating_strobe_source #(
  parameter int unsigned WIDTH   = 14,
  parameter int unsigned DEC_MAX = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             enable_i,
  input  logic [3:0]       dec_log2_i,
  output logic [WIDTH-1:0] data_o,
  output logic             data_valid_o,
  output logic             ce_o
);

  localparam int unsigned ACC_W = WIDTH + DEC_MAX;
  localparam int unsigned CNT_W = (DEC_MAX > 0) ? DEC_MAX : 1;
  localparam logic [3:0]  DEC_LIM = 4'(DEC_MAX);

  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_last;
  logic signed [ACC_W-1:0] acc_q, acc_d, sample, sum;
  logic                    ok_q, ok_d, window_good;
  logic [3:0]              dec_q, dec_d, dec_c;
  logic [WIDTH-1:0]        data_d;
  logic                    valid_d, ce_d;

  // Next-state: accumulate, close the window at cnt = N-1, abort on a dec change.
  always_comb begin
    dec_c       = (dec_log2_i > DEC_LIM) ? DEC_LIM : dec_log2_i;
    cnt_last    = CNT_W'((32'd1 << dec_q) - 32'd1);
    sample      = enable_i ? ACC_W'($signed(data_i)) : '0;
    sum         = acc_q + sample;
    window_good = ok_q & enable_i;

    cnt_d   = cnt_q + CNT_W'(1);
    acc_d   = sum;
    ok_d    = window_good;
    dec_d   = dec_q;
    data_d  = data_o;
    valid_d = 1'b0;
    ce_d    = 1'b0;

    if (dec_c != dec_q) begin
      cnt_d = '0;
      acc_d = '0;
      ok_d  = 1'b1;
      dec_d = dec_c;
    end else if (cnt_q == cnt_last) begin
      ce_d    = 1'b1;
      valid_d = window_good;
      if (window_good) begin
        data_d = WIDTH'(sum >>> dec_q);
      end
      cnt_d = '0;
      acc_d = '0;
      ok_d  = 1'b1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      acc_q        <= '0;
      ok_q         <= 1'b1;
      dec_q        <= dec_c;
      data_o       <= '0;
      data_valid_o <= 1'b0;
      ce_o         <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      ok_q         <= ok_d;
      dec_q        <= dec_d;
      data_o       <= data_d;
      data_valid_o <= valid_d;
      ce_o         <= ce_d;
    end
  end

endmodule

// File: tb/tb_decimating_strobe_source.sv
// Bench for decimating_strobe_source: vector table, directed corner sequences,
// and randomized traffic checked every cycle against a sample-list reference model.
module tb_decimating_strobe_source;

  localparam int unsigned WIDTH = 14;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic [WIDTH-1:0] data_i = '0;
  logic             enable_i = 1'b1;
  logic [3:0]       dec_log2_i = 4'd2;
  logic [WIDTH-1:0] data_o;
  logic             data_valid_o;
  logic             ce_o;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  decimating_strobe_source #(.WIDTH(WIDTH), .DEC_MAX(10)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .enable_i(enable_i),
    .dec_log2_i(dec_log2_i), .data_o(data_o), .data_valid_o(data_valid_o), .ce_o(ce_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sdata(input logic [WIDTH-1:0] v);
    return longint'($signed(v));
  endfunction

  // Reference model: window as a list of samples, mean by floor division.
  longint m_samples[$];
  bit     m_all_en;
  int     m_dec;
  longint m_data;
  bit     m_valid, m_ce;

  function automatic int clamp_dec(input logic [3:0] d);
    return (int'(d) > 10) ? 10 : int'(d);
  endfunction

  function automatic longint floor_div(input longint s, input longint n);
    longint q;
    q = s / n;
    if ((s % n) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  always @(posedge clk_i) begin
    longint total;
    if (rst_i) begin
      m_samples.delete();
      m_all_en = 1'b1;
      m_dec = clamp_dec(dec_log2_i);
      m_data = 0; m_valid = 1'b0; m_ce = 1'b0;
    end else if (clamp_dec(dec_log2_i) != m_dec) begin
      m_samples.delete();
      m_all_en = 1'b1;
      m_dec = clamp_dec(dec_log2_i);
      m_valid = 1'b0; m_ce = 1'b0;
    end else begin
      m_samples.push_back(enable_i ? sdata(data_i) : 0);
      if (!enable_i) m_all_en = 1'b0;
      m_valid = 1'b0; m_ce = 1'b0;
      if (m_samples.size() == (1 << m_dec)) begin
        total = 0;
        foreach (m_samples[k]) total += m_samples[k];
        m_ce = 1'b1;
        m_valid = m_all_en;
        if (m_all_en) m_data = floor_div(total, longint'(1 << m_dec));
        m_samples.delete();
        m_all_en = 1'b1;
      end
    end
  end

  always @(negedge clk_i) begin
    if (chk_on) begin
      check("model_ce", ce_o, m_ce);
      check("model_valid", data_valid_o, m_valid);
      check("model_data", sdata(data_o), m_data);
      check("valid_implies_ce", (data_valid_o && !ce_o) ? 1 : 0, 0);
    end
  end

  task automatic drive(input logic r, input logic [3:0] d, input logic e, input logic [WIDTH-1:0] x);
    rst_i = r; dec_log2_i = d; enable_i = e; data_i = x;
    @(negedge clk_i);
  endtask

  typedef struct {
    logic [3:0]       dec;
    logic             en;
    logic [WIDTH-1:0] din;
    logic             ce;
    logic             valid;
    logic [WIDTH-1:0] dout;
  } vec_t;

  vec_t vt[8];

  initial begin
    int n;
    // Four-sample window, data 4,8,12,16 repeating, mean 10.
    for (int i = 0; i < 8; i++) begin
      vt[i].dec   = 4'd2;
      vt[i].en    = 1'b1;
      vt[i].din   = WIDTH'(4 * ((i % 4) + 1));
      vt[i].ce    = ((i % 4) == 3);
      vt[i].valid = ((i % 4) == 3);
      vt[i].dout  = (i >= 3) ? WIDTH'(10) : WIDTH'(0);
    end

    drive(1'b1, 4'd2, 1'b1, '0);
    chk_on = 1'b1;
    check("reset_ce", ce_o, 0);
    check("reset_valid", data_valid_o, 0);
    check("reset_data", sdata(data_o), 0);
    drive(1'b1, 4'd2, 1'b1, '0);

    foreach (vt[i]) begin
      drive(1'b0, vt[i].dec, vt[i].en, vt[i].din);
      check("vec_ce", ce_o, vt[i].ce);
      check("vec_valid", data_valid_o, vt[i].valid);
      check("vec_data", sdata(data_o), sdata(vt[i].dout));
    end

    // Negative floor and full-scale averaging at dec=1.
    drive(1'b0, 4'd1, 1'b1, '0);
    check("abort_ce", ce_o, 0);
    drive(1'b0, 4'd1, 1'b1, WIDTH'(-3));
    drive(1'b0, 4'd1, 1'b1, WIDTH'(-2));
    check("floor_valid", data_valid_o, 1);
    check("floor_data", sdata(data_o), -3);
    drive(1'b0, 4'd1, 1'b1, 14'h1FFF);
    drive(1'b0, 4'd1, 1'b1, 14'h1FFF);
    check("fullscale_data", sdata(data_o), 8191);

    // dec=3 with a one-cycle enable drop: strobe without valid, then a clean window.
    drive(1'b0, 4'd3, 1'b1, '0);
    for (int i = 0; i < 8; i++) drive(1'b0, 4'd3, (i != 3), WIDTH'(77));
    check("gap_ce", ce_o, 1);
    check("gap_valid", data_valid_o, 0);
    check("gap_data_held", sdata(data_o), 8191);
    for (int i = 1; i <= 8; i++) drive(1'b0, 4'd3, 1'b1, WIDTH'(i));
    check("after_gap_valid", data_valid_o, 1);
    check("after_gap_data", sdata(data_o), 4);

    // dec=0 pass-through of a ramp.
    drive(1'b0, 4'd0, 1'b1, '0);
    check("dec0_abort_ce", ce_o, 0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 4'd0, 1'b1, WIDTH'(200 + i));
      check("dec0_valid", data_valid_o, 1);
      check("dec0_data", sdata(data_o), 200 + i);
    end

    // dec_log2_i=15 clamps to a 1024-sample window.
    drive(1'b0, 4'd15, 1'b1, '0);
    n = 0;
    do begin
      drive(1'b0, 4'd15, 1'b1, WIDTH'(n % 64));
      n++;
    end while (!ce_o && n < 1100);
    check("dec15_period", n, 1024);
    check("dec15_valid", data_valid_o, 1);

    // dec 2 -> 3 on the cnt=3 cycle: boundary suppressed, fresh 8-sample window.
    drive(1'b0, 4'd2, 1'b1, '0);
    for (int i = 0; i < 3; i++) drive(1'b0, 4'd2, 1'b1, WIDTH'(9));
    drive(1'b0, 4'd3, 1'b1, WIDTH'(50));
    check("switch_ce", ce_o, 0);
    check("switch_valid", data_valid_o, 0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 4'd3, 1'b1, WIDTH'(100 + i));
      if (ce_o) n++;
    end
    check("switch_pulses", n, 1);
    check("switch_last_ce", ce_o, 1);
    check("switch_data", sdata(data_o), 103);

    // Reset mid-window at cnt=2 with dec=2.
    drive(1'b0, 4'd2, 1'b1, '0);
    drive(1'b0, 4'd2, 1'b1, WIDTH'(40));
    drive(1'b0, 4'd2, 1'b1, WIDTH'(40));
    drive(1'b1, 4'd2, 1'b1, WIDTH'(40));
    check("rst_ce", ce_o, 0);
    check("rst_valid", data_valid_o, 0);
    check("rst_data", sdata(data_o), 0);
    n = 0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 4'd2, 1'b1, WIDTH'(i));
      if (ce_o) n = i;
    end
    check("rst_first_pulse", n, 4);
    check("rst_mean", sdata(data_o), 2);

    // Randomized traffic checked by the model.
    begin
      logic [3:0] d;
      d = 4'd2;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 149) == 0) d = 4'($urandom_range(0, 4));
        if ($urandom_range(0, 999) == 0) d = 4'd11 + 4'($urandom_range(0, 4));
        if (d > 4'd4 && $urandom_range(0, 99) == 0) d = 4'd1;
        drive(($urandom_range(0, 299) == 0), d, ($urandom_range(0, 11) != 0),
              WIDTH'($urandom_range(0, 16383)));
      end
    end

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decimating_strobe_source.md
DECIMATING_STROBE_SOURCE -- requirements
Module: decimating_strobe_source

Interface
REQ-001 The block SHALL have parameter WIDTH, default 14: sample width of data_i and data_o, two's complement.
REQ-002 The block SHALL have parameter DEC_MAX, default 10: largest supported log2 decimation factor.
REQ-003 The block SHALL have port clk_i, input, 1 bit: single clock; all logic on rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port data_i, input, WIDTH bits: raw ADC sample, one new sample every clock.
REQ-006 The block SHALL have port enable_i, input, 1 bit: accumulate samples when high.
REQ-007 The block SHALL have port dec_log2_i, input, 4 bits: log2 of decimation factor N = 2^dec.
REQ-008 The block SHALL have port data_o, output, WIDTH bits: window mean, held between valid pulses.
REQ-009 The block SHALL have port data_valid_o, output, 1 bit: one-cycle pulse marking a new valid data_o.
REQ-010 The block SHALL have port ce_o, output, 1 bit: one-cycle timekeeping pulse at every window boundary.

Function
REQ-011 The block SHALL clamp dec_log2_i values above DEC_MAX to DEC_MAX.
REQ-012 The block SHALL register the clamped value as dec_q and compare it each cycle against the clamped input.
REQ-013 The block SHALL keep a window counter cnt running 0..N-1 every clock, independent of enable_i.
REQ-014 The block SHALL use an accumulator WIDTH+DEC_MAX bits wide, signed, so it never overflows.
REQ-015 The block SHALL add sign-extended data_i to the accumulator in every cycle with enable_i=1.
REQ-016 The block SHALL keep a window_ok flag, set at window start and cleared by any cycle in the window with enable_i=0.
REQ-017 The block SHALL treat the cycle with cnt=N-1 as the boundary; the final sum includes that cycle's data_i.
REQ-018 On the cycle after a boundary, ce_o SHALL be 1 and data_valid_o SHALL equal window_ok for that window.
REQ-019 Latency from the last sample of a window to ce_o/data_valid_o SHALL be exactly 1 clock.
REQ-020 data_o SHALL update only together with data_valid_o=1, to the sum arithmetically shifted right by dec_q (floor division).
REQ-021 When data_valid_o=0 (including ce_o=1 with window_ok=0), data_o SHALL hold its previous value.
REQ-022 At a boundary the accumulator SHALL load the next window's first contribution: 0, or data_i if enable_i=1 in that cycle's successor; no sample is lost or double-counted.
REQ-023 When dec=0, ce_o SHALL pulse every cycle; with enable_i=1, data_o SHALL equal data_i delayed by 1 clock and data_valid_o SHALL stay high.
REQ-024 When dec_log2_i changes, the block SHALL abort the current window in the same cycle: cnt=0, accumulator=0, window_ok=1, dec_q updated.
REQ-025 An aborted window SHALL produce no ce_o and no data_valid_o.
REQ-026 If a dec change coincides with a boundary, the abort SHALL win: no pulse next cycle.
REQ-027 data_valid_o SHALL never be high when ce_o is low.

Reset
REQ-028 While rst_i=1 at a clock edge, the block SHALL clear cnt, accumulator, data_o, data_valid_o and ce_o to 0, set window_ok=1, and load dec_q from the clamped dec_log2_i.
REQ-029 The first window SHALL begin on the first clock with rst_i=0; reset asserted mid-window discards the partial window with no pulse.

Verification
REQ-030 dec=2, enable=1, data_i=4,8,12,16 repeating -> ce_o and data_valid_o pulse every 4 clocks; data_o=10; first pulse 1 clock after 4th sample.
REQ-031 dec=1, samples -3,-2 -> data_o=-3 (floor of -2.5); samples 0x1FFF,0x1FFF at WIDTH=14 -> data_o=0x1FFF, no overflow.
REQ-032 dec=3, enable_i low for one cycle mid-window -> ce_o pulses at the boundary, data_valid_o=0, data_o unchanged; next full window valid.
REQ-033 dec=0, ramp input -> data_valid_o constantly high, data_o = data_i delayed by 1; dec_log2_i=15 -> behaves as dec=10 (pulse every 1024 clocks).
REQ-034 dec 2 -> 3 switched on cycle cnt=3 -> no pulse at that boundary; next pulse 8 clocks after the switch, mean of the 8 new samples.
REQ-035 rst_i pulsed at cnt=2 with dec=2 -> all outputs 0 next cycle; first pulse 4 clocks after reset release.
